// File: rtl/frame_upload_scheduler.sv
// Frame-by-frame sequencer for the pixel uploader DMA. It gates the uploader
// enable, relatches base/size at each frame boundary and ping-pongs between two buffers.
module frame_upload_scheduler #(
  parameter int unsigned GAP_CYCLES  = 4,
  parameter int unsigned FRAME_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_start,
  input  logic                   cfg_stop,
  input  logic                   cfg_err_clear,
  input  logic [31:0]            cfg_buf0_addr,
  input  logic [31:0]            cfg_buf1_addr,
  input  logic [31:0]            cfg_frame_bytes,
  input  logic [23:0]            cfg_frame_words,
  input  logic                   swap_req,
  input  logic                   upl_active,
  input  logic                   upl_read_error,
  input  logic                   upl_fifo_write,
  output logic                   upl_enable,
  output logic [31:0]            upl_base_address,
  output logic [31:0]            upl_total_size,
  output logic                   swap_ack,
  output logic                   frame_done,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic                   cur_buf,
  output logic                   error_flag,
  output logic                   busy
);

  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_GAP,
    S_ERROR
  } state_e;

  state_e                 state_q, state_d;
  logic [23:0]            word_cnt_q, word_cnt_d;
  logic [23:0]            frame_words_q, frame_words_d;
  logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;
  logic                   swap_pending_q, swap_pending_d;
  logic                   stop_pending_q, stop_pending_d;
  logic                   upl_enable_q, upl_enable_d;
  logic [31:0]            upl_base_address_q, upl_base_address_d;
  logic [31:0]            upl_total_size_q, upl_total_size_d;
  logic                   swap_ack_q, swap_ack_d;
  logic                   frame_done_q, frame_done_d;
  logic [FRAME_CNT_W-1:0] frame_count_q, frame_count_d;
  logic                   cur_buf_q, cur_buf_d;
  logic                   error_flag_q, error_flag_d;
  logic                   busy_q, busy_d;

  logic streaming;
  logic err_hit;
  logic do_swap;
  logic new_buf;

  assign streaming = (state_q == S_RUN) || (state_q == S_DRAIN) || (state_q == S_GAP);
  assign err_hit   = streaming && upl_read_error;
  assign do_swap   = swap_pending_q || swap_req;
  assign new_buf   = cur_buf_q ^ do_swap;

  // NOTE: every _d gets a default before any branch so no path leaves it
  // unassigned; that is what keeps this block free of inferred latches.
  always_comb begin
    state_d            = state_q;
    word_cnt_d         = word_cnt_q;
    frame_words_d      = frame_words_q;
    gap_cnt_d          = gap_cnt_q;
    swap_pending_d     = swap_pending_q;
    stop_pending_d     = stop_pending_q;
    upl_base_address_d = upl_base_address_q;
    upl_total_size_d   = upl_total_size_q;
    swap_ack_d         = 1'b0;
    frame_done_d       = 1'b0;
    frame_count_d      = frame_count_q;
    cur_buf_d          = cur_buf_q;
    error_flag_d       = error_flag_q;

    if (err_hit) begin
      // A read error aborts the frame outright, even on its final word.
      state_d        = S_ERROR;
      error_flag_d   = 1'b1;
      word_cnt_d     = '0;
      gap_cnt_d      = '0;
      swap_pending_d = 1'b0;
      stop_pending_d = 1'b0;
    end else begin
      if (streaming) begin
        if (swap_req) swap_pending_d = 1'b1;
        if (cfg_stop) stop_pending_d = 1'b1;
      end

      unique case (state_q)
        S_IDLE: begin
          if (cfg_start && !cfg_stop && (cfg_frame_words != '0)) begin
            upl_base_address_d = cur_buf_q ? cfg_buf1_addr : cfg_buf0_addr;
            upl_total_size_d   = cfg_frame_bytes;
            frame_words_d      = cfg_frame_words;
            word_cnt_d         = '0;
            gap_cnt_d          = '0;
            state_d            = S_GAP;
          end
        end
        S_RUN: begin
          if (upl_fifo_write) begin
            if (word_cnt_q == frame_words_q - 24'd1) begin
              word_cnt_d = '0;
              state_d    = S_DRAIN;
            end else begin
              word_cnt_d = word_cnt_q + 24'd1;
            end
          end
        end
        S_DRAIN: begin
          if (!upl_active) begin
            frame_done_d       = 1'b1;
            frame_count_d      = frame_count_q + FRAME_CNT_W'(1);
            cur_buf_d          = new_buf;
            swap_ack_d         = do_swap;
            swap_pending_d     = 1'b0;
            upl_base_address_d = new_buf ? cfg_buf1_addr : cfg_buf0_addr;
            upl_total_size_d   = cfg_frame_bytes;
            frame_words_d      = cfg_frame_words;
            gap_cnt_d          = '0;
            state_d            = S_GAP;
          end
        end
        S_GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            gap_cnt_d = '0;
            if (stop_pending_q) begin
              stop_pending_d = 1'b0;
              state_d        = S_IDLE;
            end else begin
              state_d = S_RUN;
            end
          end else begin
            gap_cnt_d = gap_cnt_q + GAP_W'(1);
          end
        end
        S_ERROR: begin
          if (cfg_err_clear) begin
            error_flag_d = 1'b0;
            state_d      = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Outputs follow the next state so they line up with the state register.
    upl_enable_d = (state_d == S_RUN);
    busy_d       = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q            <= S_IDLE;
      word_cnt_q         <= '0;
      frame_words_q      <= '0;
      gap_cnt_q          <= '0;
      swap_pending_q     <= 1'b0;
      stop_pending_q     <= 1'b0;
      upl_enable_q       <= 1'b0;
      upl_base_address_q <= '0;
      upl_total_size_q   <= '0;
      swap_ack_q         <= 1'b0;
      frame_done_q       <= 1'b0;
      frame_count_q      <= '0;
      cur_buf_q          <= 1'b0;
      error_flag_q       <= 1'b0;
      busy_q             <= 1'b0;
    end else begin
      state_q            <= state_d;
      word_cnt_q         <= word_cnt_d;
      frame_words_q      <= frame_words_d;
      gap_cnt_q          <= gap_cnt_d;
      swap_pending_q     <= swap_pending_d;
      stop_pending_q     <= stop_pending_d;
      upl_enable_q       <= upl_enable_d;
      upl_base_address_q <= upl_base_address_d;
      upl_total_size_q   <= upl_total_size_d;
      swap_ack_q         <= swap_ack_d;
      frame_done_q       <= frame_done_d;
      frame_count_q      <= frame_count_d;
      cur_buf_q          <= cur_buf_d;
      error_flag_q       <= error_flag_d;
      busy_q             <= busy_d;
    end
  end

  assign upl_enable       = upl_enable_q;
  assign upl_base_address = upl_base_address_q;
  assign upl_total_size   = upl_total_size_q;
  assign swap_ack         = swap_ack_q;
  assign frame_done       = frame_done_q;
  assign frame_count      = frame_count_q;
  assign cur_buf          = cur_buf_q;
  assign error_flag       = error_flag_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_frame_upload_scheduler.sv
// Scoreboard bench: stimulus pushes per-frame expectations, a negedge monitor
// pops them on each enable rise and frame_done pulse.
module tb_frame_upload_scheduler;

  localparam int GAP = 4;
  localparam int CW  = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_start = 1'b0, cfg_stop = 1'b0, cfg_err_clear = 1'b0;
  logic [31:0]   cfg_buf0_addr = '0, cfg_buf1_addr = '0, cfg_frame_bytes = '0;
  logic [23:0]   cfg_frame_words = '0;
  logic          swap_req = 1'b0, upl_active = 1'b0, upl_read_error = 1'b0, upl_fifo_write = 1'b0;
  logic          upl_enable;
  logic [31:0]   upl_base_address, upl_total_size;
  logic          swap_ack, frame_done;
  logic [CW-1:0] frame_count;
  logic          cur_buf, error_flag, busy;

  frame_upload_scheduler #(.GAP_CYCLES(GAP), .FRAME_CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_err_clear(cfg_err_clear),
    .cfg_buf0_addr(cfg_buf0_addr), .cfg_buf1_addr(cfg_buf1_addr),
    .cfg_frame_bytes(cfg_frame_bytes), .cfg_frame_words(cfg_frame_words),
    .swap_req(swap_req), .upl_active(upl_active), .upl_read_error(upl_read_error),
    .upl_fifo_write(upl_fifo_write), .upl_enable(upl_enable),
    .upl_base_address(upl_base_address), .upl_total_size(upl_total_size),
    .swap_ack(swap_ack), .frame_done(frame_done), .frame_count(frame_count),
    .cur_buf(cur_buf), .error_flag(error_flag), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] base;
    logic [31:0] total;
  } start_t;

  typedef struct {
    int          count;
    bit          cur;
    bit          ack;
    logic [31:0] base;
    logic [31:0] total;
  } done_t;

  start_t start_q[$];
  done_t  done_q[$];

  int n_checks = 0;
  int n_errors = 0;

  // Transaction-level reference state.
  bit          m_cur   = 1'b0;
  int          m_count = 0;
  logic [23:0] m_words = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_stream();
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    start_q.push_back('{base: (m_cur ? cfg_buf1_addr : cfg_buf0_addr), total: cfg_frame_bytes});
    m_words = cfg_frame_words;
  endtask

  task automatic wait_enable(output bit ok);
    int t = 0;
    while (upl_enable !== 1'b1 && t < 100) begin
      step();
      t++;
    end
    ok = (upl_enable === 1'b1);
    check("enable_rise_in_time", 32'(ok), 32'd1);
    if (ok) check("gap_cycles_before_rise", 32'(t), 32'(GAP));
  endtask

  task automatic randomize_cfg();
    cfg_buf0_addr   = $urandom & 32'hFFFF_FFF0;
    cfg_buf1_addr   = $urandom & 32'hFFFF_FFF0;
    cfg_frame_bytes = 32'($urandom_range(1, 4096));
    cfg_frame_words = 24'($urandom_range(1, 6));
  endtask

  // One uploader frame: words strobes, optional drain-phase strobes, then active falls.
  task automatic do_frame(input bit stop, input int mid_swaps, input bit bnd_swap, input bit rnd_cfg);
    bit ok;
    int words;
    int idle;
    int hold;
    bit swap_any;
    wait_enable(ok);
    if (!ok) return;
    words = int'(m_words);
    upl_active = 1'b1;
    for (int w = 0; w < words; w++) begin
      idle = $urandom_range(0, 2);
      for (int i = 0; i < idle; i++) step();
      upl_fifo_write = 1'b1;
      swap_req       = (w < mid_swaps);
      cfg_stop       = stop && (w == 0);
      if (rnd_cfg && w == 0) randomize_cfg();
      step();
      upl_fifo_write = 1'b0;
      swap_req       = 1'b0;
      cfg_stop       = 1'b0;
    end
    check("enable_drop_after_last_word", 32'(upl_enable), 32'd0);
    hold = $urandom_range(0, 3);
    for (int i = 0; i < hold; i++) begin
      upl_fifo_write = 1'($urandom_range(0, 1));
      step();
    end
    upl_fifo_write = 1'b0;
    upl_active     = 1'b0;
    swap_req       = bnd_swap;
    step();
    swap_req = 1'b0;
    swap_any = (mid_swaps > 0) || bnd_swap;
    m_cur    = m_cur ^ swap_any;
    m_count  = (m_count + 1) % (1 << CW);
    done_q.push_back('{count: m_count, cur: m_cur, ack: swap_any,
                       base: (m_cur ? cfg_buf1_addr : cfg_buf0_addr), total: cfg_frame_bytes});
    if (!stop) start_q.push_back('{base: (m_cur ? cfg_buf1_addr : cfg_buf0_addr), total: cfg_frame_bytes});
    m_words = cfg_frame_words;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < GAP + 1; i++) step();
    check(name, 32'({busy, upl_enable}), 32'd0);
  endtask

  // Monitor
  start_t mon_s;
  done_t  mon_d;
  logic   mon_prev_en = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (upl_enable && !mon_prev_en) begin
        check("start_expected", 32'(start_q.size() != 0), 32'd1);
        if (start_q.size() != 0) begin
          mon_s = start_q.pop_front();
          check("start_base", upl_base_address, mon_s.base);
          check("start_total", upl_total_size, mon_s.total);
        end
      end
      if (frame_done) begin
        check("done_expected", 32'(done_q.size() != 0), 32'd1);
        if (done_q.size() != 0) begin
          mon_d = done_q.pop_front();
          check("done_count", 32'(frame_count), 32'(mon_d.count));
          check("done_cur_buf", 32'(cur_buf), 32'(mon_d.cur));
          check("done_swap_ack", 32'(swap_ack), 32'(mon_d.ack));
          check("done_base", upl_base_address, mon_d.base);
          check("done_total", upl_total_size, mon_d.total);
        end
      end
      if (swap_ack) check("swap_ack_only_at_boundary", 32'(frame_done), 32'd1);
      mon_prev_en = upl_enable;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    int nfr;

    // Reset state
    step();
    check("reset_flags", 32'({upl_enable, swap_ack, frame_done, cur_buf, error_flag, busy}), 32'd0);
    check("reset_base", upl_base_address, 32'd0);
    check("reset_total", upl_total_size, 32'd0);
    check("reset_count", 32'(frame_count), 32'd0);
    rst_n = 1'b1;
    step();

    // Zero-word start and start+stop are both ignored
    cfg_buf0_addr   = 32'h1000;
    cfg_buf1_addr   = 32'h8000;
    cfg_frame_bytes = 32'd32;
    cfg_frame_words = 24'd0;
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    wait_idle("zero_words_stays_idle");
    cfg_frame_words = 24'd8;
    cfg_start = 1'b1;
    cfg_stop  = 1'b1;
    step();
    cfg_start = 1'b0;
    cfg_stop  = 1'b0;
    wait_idle("start_with_stop_stays_idle");
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    step();
    check("idle_swap_ignored", 32'(cur_buf), 32'(m_cur));

    // Single frame, stop during the frame
    start_stream();
    check("single_base", upl_base_address, 32'h1000);
    check("single_total", upl_total_size, 32'd32);
    do_frame(1'b1, 0, 1'b0, 1'b0);
    wait_idle("single_back_to_idle");
    check("single_count", 32'(frame_count), 32'd1);

    // Continuous with swaps: single, collapsed+boundary, then one more and stop
    start_stream();
    do_frame(1'b0, 1, 1'b0, 1'b0);
    do_frame(1'b0, 3, 1'b1, 1'b0);
    do_frame(1'b1, 1, 1'b0, 1'b0);
    wait_idle("swap_seq_idle");
    check("swap_seq_cur_buf", 32'(cur_buf), 32'(m_cur));

    // Read error on the 5th word, with a pending swap that must be discarded
    cfg_frame_words = 24'd8;
    start_stream();
    wait_enable(ok);
    upl_active = 1'b1;
    for (int w = 0; w < 5; w++) begin
      upl_fifo_write = 1'b1;
      swap_req       = (w == 1);
      upl_read_error = (w == 4);
      step();
      upl_fifo_write = 1'b0;
      swap_req       = 1'b0;
      upl_read_error = 1'b0;
    end
    upl_active = 1'b0;
    check("err_enable_low", 32'(upl_enable), 32'd0);
    check("err_flag_set", 32'({error_flag, busy}), 32'd3);
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    for (int i = 0; i < GAP + 1; i++) step();
    check("err_start_ignored", 32'({error_flag, busy, upl_enable}), 32'd6);
    cfg_err_clear = 1'b1;
    step();
    cfg_err_clear = 1'b0;
    check("err_cleared", 32'({error_flag, busy}), 32'd0);
    check("err_count_unchanged", 32'(frame_count), 32'(m_count));
    check("err_cur_buf_unchanged", 32'(cur_buf), 32'(m_cur));
    start_stream();
    do_frame(1'b1, 0, 1'b0, 1'b0);
    wait_idle("post_err_idle");

    // Async reset mid-frame, then fresh start and wrap after five frames
    if (!m_cur) begin
      start_stream();
      do_frame(1'b1, 1, 1'b0, 1'b0);
      wait_idle("pre_reset_idle");
    end
    start_stream();
    wait_enable(ok);
    upl_active = 1'b1;
    for (int w = 0; w < 3; w++) begin
      upl_fifo_write = 1'b1;
      step();
      upl_fifo_write = 1'b0;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_flags", 32'({upl_enable, swap_ack, frame_done, cur_buf, error_flag, busy}), 32'd0);
    check("async_rst_base", upl_base_address, 32'd0);
    check("async_rst_total", upl_total_size, 32'd0);
    check("async_rst_count", 32'(frame_count), 32'd0);
    upl_active = 1'b0;
    m_cur   = 1'b0;
    m_count = 0;
    step();
    step();
    rst_n = 1'b1;
    step();
    cfg_frame_words = 24'd3;
    start_stream();
    for (int i = 0; i < 5; i++) do_frame(i == 4, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b1);
    wait_idle("wrap_idle");
    check("wrap_count", 32'(frame_count), 32'd1);

    // Randomized segments
    for (int seg = 0; seg < 5; seg++) begin
      randomize_cfg();
      start_stream();
      nfr = $urandom_range(2, 4);
      for (int i = 0; i < nfr; i++)
        do_frame(i == nfr - 1, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b1);
      wait_idle("rand_seg_idle");
    end

    step();
    check("start_q_drained", 32'(start_q.size()), 32'd0);
    check("done_q_drained", 32'(done_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
